// File: rtl/feg_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// latched decoder strobes and the opcode map.
package feg_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b001;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b010;
  localparam logic [OP_W-1:0] OP_LW   = 3'b011;
  localparam logic [OP_W-1:0] OP_SW   = 3'b100;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'b101;
  localparam logic [OP_W-1:0] OP_HALT = 3'b110;
  localparam logic [OP_W-1:0] OP_ADDI = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } seq_state_t;

  typedef struct packed {
    logic memwr;
    logic memrd;
    logic regwr;
    logic branch;
  } dec_bits_t;

  function automatic logic is_busy(input seq_state_t s);
    return (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
           (s == S_MEM)   || (s == S_WB);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Counts consecutive cycles spent waiting on memory; expired flags the
// last permitted wait cycle so the caller can give up on the same edge.
module wait_timer #(
  parameter int TMO = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [W-1:0] LAST = W'(TMO - 1);

  logic [W-1:0] r_cnt;
  logic         w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign o_expired = i_en && w_at_last;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_at_last) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a timed memory
// handshake; every output is decoded from registered state only.
module instr_sequencer #(
  parameter int                OPW     = 3,
  parameter logic [OPW-1:0]    HALT_OP = feg_pkg::OP_HALT,
  parameter int                TMO     = 15,
  parameter int                CNTW    = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [OPW-1:0]  i_op,
  input  logic            i_dec_memwr,
  input  logic            i_dec_memrd,
  input  logic            i_dec_regwr,
  input  logic            i_dec_branch,
  input  logic            i_mem_ack,
  output logic            o_ir_load,
  output logic            o_pc_inc,
  output logic            o_pc_load,
  output logic            o_reg_we,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [CNTW-1:0] o_retired
);
  import feg_pkg::*;

  seq_state_t      r_state;
  seq_state_t      w_next;
  dec_bits_t       r_dec;
  logic [CNTW-1:0] r_retired;
  logic            w_tmr_clr;
  logic            w_tmr_en;
  logic            w_tmr_expired;

  // Timer only runs while a request is outstanding and unanswered.
  assign w_tmr_en  = (r_state == S_MEM) && !i_mem_ack;
  assign w_tmr_clr = (r_state != S_MEM) || i_mem_ack;

  wait_timer #(.TMO(TMO)) u_wait_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_tmr_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_dec     <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_dec <= '{memwr:  i_dec_memwr,
                   memrd:  i_dec_memrd,
                   regwr:  i_dec_regwr,
                   branch: i_dec_branch};
      end
      if ((r_state == S_WB) && (r_retired != {CNTW{1'b1}})) begin
        r_retired <= r_retired + 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (i_op == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC:   w_next = (r_dec.memrd || r_dec.memwr) ? S_MEM : S_WB;
      // A late ack on the final permitted cycle still completes.
      S_MEM: begin
        if (i_mem_ack)          w_next = S_WB;
        else if (w_tmr_expired) w_next = S_ERR;
      end
      S_WB:     w_next = S_FETCH;
      S_HALT:   if (i_start) w_next = S_FETCH;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ir_load = 1'b0;
    o_pc_inc  = 1'b0;
    o_pc_load = 1'b0;
    o_reg_we  = 1'b0;
    o_mem_req = 1'b0;
    o_mem_we  = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;
    case (r_state)
      S_FETCH: o_ir_load = 1'b1;
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = r_dec.memwr;
      end
      S_WB: begin
        o_reg_we  = r_dec.regwr & ~r_dec.memwr;
        o_pc_load = r_dec.branch;
        o_pc_inc  = ~r_dec.branch;
      end
      S_HALT:  o_done = 1'b1;
      S_ERR:   o_err  = 1'b1;
      default: ;
    endcase
    o_busy = is_busy(r_state);
  end

  assign o_retired = r_retired;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed table, hand-written corner sequences
// and a randomized instruction stream against a per-instruction trace model.
module tb_instr_sequencer;

  localparam int TMO  = 15;
  localparam int CNTW = 4;
  localparam logic [2:0] HALT = 3'b110;
  localparam int RET_MAX = (1 << CNTW) - 1;

  // {ir_load, pc_inc, pc_load, reg_we, mem_req, mem_we, busy, done, err}
  localparam logic [8:0] ZERO = 9'b000000000;
  localparam logic [8:0] BUSY = 9'b000000100;
  localparam logic [8:0] DONE = 9'b000000010;
  localparam logic [8:0] ERRV = 9'b000000001;

  typedef struct {
    logic [2:0] op;
    logic wr;
    logic rd;
    logic rg;
    logic br;
    int   waits;
  } instr_t;

  typedef struct {
    string      nm;
    instr_t     in;
    int         cycles;
    int         nreq;
    logic [2:0] wb;   // {reg_we, pc_inc, pc_load}
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, memwr, memrd, regwr, branch, ack;
  logic [2:0] op;
  logic o_ir_load, o_pc_inc, o_pc_load, o_reg_we, o_mem_req, o_mem_we;
  logic o_busy, o_done, o_err;
  logic [CNTW-1:0] o_retired;

  int n_chk = 0, n_fail = 0, cyc = 0, exp_ret = 0;
  int g_req, g_cycles;
  bit g_err, g_abort;
  logic [2:0] g_wb;

  instr_sequencer #(.CNTW(CNTW), .TMO(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_op(op),
    .i_dec_memwr(memwr), .i_dec_memrd(memrd), .i_dec_regwr(regwr),
    .i_dec_branch(branch), .i_mem_ack(ack),
    .o_ir_load(o_ir_load), .o_pc_inc(o_pc_inc), .o_pc_load(o_pc_load),
    .o_reg_we(o_reg_we), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_retired(o_retired)
  );

  function automatic logic [8:0] mk(logic ir, logic inc, logic ld, logic we,
                                    logic req, logic mwe, logic bsy);
    return {ir, inc, ld, we, req, mwe, bsy, 1'b0, 1'b0};
  endfunction

  function automatic logic [8:0] obs();
    return {o_ir_load, o_pc_inc, o_pc_load, o_reg_we, o_mem_req, o_mem_we,
            o_busy, o_done, o_err};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction
  function automatic logic [3:0] rdec();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
    end
  endtask

  // Compare the current cycle, drive inputs for the next edge, advance.
  task automatic step(input logic [8:0] e, input logic r, input logic st,
                      input logic a, input logic [2:0] o, input logic [3:0] d,
                      input bit wb);
    check("outputs", 32'(obs()), 32'(e));
    check("retired", 32'(o_retired), 32'(exp_ret));
    g_req += int'(o_mem_req);
    if (wb) g_wb = {o_reg_we, o_pc_inc, o_pc_load};
    rst = r; start = st; ack = a; op = o;
    {memwr, memrd, regwr, branch} = d;
    @(posedge clk); #1;
    cyc++;
    if (r) exp_ret = 0;
    else if (wb && exp_ret < RET_MAX) exp_ret++;
  endtask

  // Expected trace of one instruction starting at its FETCH cycle.
  task automatic exec_instr(input instr_t in, input int rst_at);
    logic [3:0] d;
    logic a, r;
    bit go;
    int c0;
    d = {in.wr, in.rd, in.rg, in.br};
    g_req = 0; g_err = 0; g_abort = 0; g_wb = '0; c0 = cyc;
    step(mk(1, 0, 0, 0, 0, 0, 1), 0, rb(), rb(), rop(), rdec(), 0);
    step(BUSY, 0, rb(), rb(), in.op, d, 0);
    if (in.op != HALT) begin
      step(BUSY, 0, rb(), rb(), rop(), rdec(), 0);
      if (in.rd || in.wr) begin
        go = 1;
        for (int k = 0; k < TMO && go; k++) begin
          a = (k == in.waits);
          r = (k == rst_at);
          step(mk(0, 0, 0, 0, 1, in.wr, 1), r, rb(), a, rop(), rdec(), 0);
          if (r) begin g_abort = 1; go = 0; end
          else if (a) go = 0;
          else if (k == TMO - 1) g_err = 1;
        end
      end
      if (!g_abort && !g_err)
        step(mk(0, ~in.br, in.br, in.rg & ~in.wr, 0, 0, 1), 0, rb(), rb(), rop(), rdec(), 1);
    end
    g_cycles = cyc - c0;
  endtask

  task automatic halt_resume(input int n);
    repeat (n) step(DONE, 0, 0, rb(), rop(), rdec(), 0);
    step(DONE, 0, 1, rb(), rop(), rdec(), 0);
  endtask

  task automatic recover();
    repeat (2) step(ERRV, 0, rb(), rb(), rop(), rdec(), 0);
    step(ERRV, 1, 0, rb(), rop(), rdec(), 0);
    step(ZERO, 0, 1, rb(), rop(), rdec(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   tbl[10];
    instr_t ri;
    int     sel;

    tbl[0] = '{"add",       '{3'b001, 0, 0, 1, 0, 0},  4,  0, 3'b110};
    tbl[1] = '{"add_b2b",   '{3'b001, 0, 0, 1, 0, 0},  4,  0, 3'b110};
    tbl[2] = '{"load_w2",   '{3'b011, 0, 1, 0, 0, 2},  7,  3, 3'b010};
    tbl[3] = '{"store",     '{3'b100, 1, 0, 0, 0, 0},  5,  1, 3'b010};
    tbl[4] = '{"store_rg",  '{3'b100, 1, 0, 1, 0, 0},  5,  1, 3'b010};
    tbl[5] = '{"branch",    '{3'b101, 0, 0, 0, 1, 0},  4,  0, 3'b001};
    tbl[6] = '{"branch_rg", '{3'b101, 0, 0, 1, 1, 0},  4,  0, 3'b101};
    tbl[7] = '{"load_rg",   '{3'b011, 0, 1, 1, 0, 0},  5,  1, 3'b110};
    tbl[8] = '{"load_late", '{3'b011, 0, 1, 1, 0, 14}, 19, 15, 3'b110};
    tbl[9] = '{"nop",       '{3'b000, 0, 0, 0, 0, 0},  4,  0, 3'b010};

    rst = 1; start = 0; ack = 0; op = '0;
    {memwr, memrd, regwr, branch} = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state, then IDLE holds without start and ignores a stray ack.
    step(ZERO, 0, 0, 1, rop(), rdec(), 0);
    step(ZERO, 0, 1, 0, rop(), rdec(), 0);

    foreach (tbl[i]) begin
      exec_instr(tbl[i].in, -1);
      check({tbl[i].nm, "_lat"}, 32'(g_cycles), 32'(tbl[i].cycles));
      check({tbl[i].nm, "_req"}, 32'(g_req), 32'(tbl[i].nreq));
      check({tbl[i].nm, "_wb"},  32'(g_wb), 32'(tbl[i].wb));
    end

    // Halt: done holds, nothing retires, start resumes with a fetch.
    exec_instr('{HALT, 0, 0, 1, 0, 0}, -1);
    check("halt_lat", 32'(g_cycles), 32'd2);
    halt_resume(3);
    check("halt_ret", 32'(o_retired), 32'd10);
    exec_instr('{3'b001, 0, 0, 1, 0, 0}, -1);

    // Memory timeout with no ack: 15 request cycles, then sticky error.
    exec_instr('{3'b011, 0, 1, 1, 0, 99}, -1);
    check("tmo_req", 32'(g_req), 32'd15);
    check("tmo_lat", 32'(g_cycles), 32'd18);
    recover();

    // Reset during MEM abandons the instruction and clears the count.
    exec_instr('{3'b001, 0, 0, 1, 0, 0}, -1);
    exec_instr('{3'b011, 0, 1, 1, 0, 99}, 2);
    check("rst_req", 32'(g_req), 32'd3);
    step(ZERO, 0, 0, 0, rop(), rdec(), 0);
    check("rst_ret", 32'(o_retired), 32'd0);

    // Retired count saturates at all-ones.
    step(ZERO, 0, 1, 0, rop(), rdec(), 0);
    repeat (RET_MAX + 2) exec_instr('{3'b001, 0, 0, 1, 0, 0}, -1);
    check("ret_sat", 32'(o_retired), 32'(RET_MAX));

    for (int n = 0; n < 300; n++) begin
      ri.op = rop();
      sel = $urandom_range(0, 3);
      ri.rd = (sel == 1);
      ri.wr = (sel == 2);
      ri.rg = rb();
      ri.br = rb();
      sel = $urandom_range(0, 19);
      ri.waits = (sel == 0) ? 99 : (sel == 1) ? TMO - 1 : $urandom_range(0, 4);
      exec_instr(ri, -1);
      if (ri.op == HALT) halt_resume($urandom_range(0, 3));
      else if (g_err) recover();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
